// File: rtl/f2i_seq.sv
//==============================================================================
// Module      : f2i_seq
// Description : Sequential IEEE-754 single to 16-bit unsigned integer converter.
//               It uses a bit-serial right shifter, and the ready/valid
//               handshake holds the result until the consumer takes it.
//               Define F2I_ROUND_EN for round-to-nearest-even; without it
//               the result is truncated toward zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module f2i_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] f_number,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] i_number,
    output logic        ovf,
    output logic        neg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_EXP_MAX    = 8'd142;
    localparam logic [7:0] c_SHIFT_BASE = 8'd150;
`ifdef F2I_ROUND_EN
    // 0.5..1.0 must reach the rounder, so exponent 126 also takes the shift path
    localparam logic [7:0] c_EXP_MIN    = 8'd126;
`else
    localparam logic [7:0] c_EXP_MIN    = 8'd127;
`endif

    state_t      r_state, w_state_n;
    logic [23:0] r_sig, w_sig_n;
    logic [4:0]  r_cnt, w_cnt_n;
    logic [15:0] r_inum, w_inum_n;
    logic        r_ovf, w_ovf_n;
    logic        r_neg, w_neg_n;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [23:0] w_shifted;

    assign w_sign    = f_number[31];
    assign w_exp     = f_number[30:23];
    assign w_man     = f_number[22:0];
    assign w_shifted = r_sig >> 1;

`ifdef F2I_ROUND_EN
    logic        r_guard, w_guard_n;
    logic        r_sticky, w_sticky_n;
    logic        w_rnd_up;
    logic [16:0] w_rnd_sum;

    // Guard/sticky seen after the final shift: guard is the bit dropped on this edge
    assign w_rnd_up  = r_sig[0] && (r_sticky || r_guard || w_shifted[0]);
    assign w_rnd_sum = {1'b0, w_shifted[15:0]} + 17'd1;
`endif

    always_comb begin
        w_state_n = r_state;
        w_sig_n   = r_sig;
        w_cnt_n   = r_cnt;
        w_inum_n  = r_inum;
        w_ovf_n   = r_ovf;
        w_neg_n   = r_neg;
`ifdef F2I_ROUND_EN
        w_guard_n  = r_guard;
        w_sticky_n = r_sticky;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_n = DONE;
                    w_inum_n  = 16'h0000;
                    w_ovf_n   = 1'b0;
                    w_neg_n   = 1'b0;
                    if (w_exp == 8'hFF) begin
                        w_inum_n = 16'hFFFF;
                        w_ovf_n  = 1'b1;
                    end else if (w_sign && (f_number[30:0] != 31'd0)) begin
                        w_neg_n = 1'b1;
                    end else if (w_exp > c_EXP_MAX) begin
                        w_inum_n = 16'hFFFF;
                        w_ovf_n  = 1'b1;
                    end else if (w_exp >= c_EXP_MIN) begin
                        w_sig_n   = {1'b1, w_man};
                        w_cnt_n   = 5'(c_SHIFT_BASE - w_exp);
                        w_state_n = SHIFT;
`ifdef F2I_ROUND_EN
                        w_guard_n  = 1'b0;
                        w_sticky_n = 1'b0;
`endif
                    end
                end
            end
            SHIFT: begin
                w_sig_n = w_shifted;
                w_cnt_n = r_cnt - 5'd1;
`ifdef F2I_ROUND_EN
                w_guard_n  = r_sig[0];
                w_sticky_n = r_sticky | r_guard;
`endif
                if (r_cnt == 5'd1) begin
                    w_state_n = DONE;
                    w_inum_n  = w_shifted[15:0];
`ifdef F2I_ROUND_EN
                    if (w_rnd_up) begin
                        if (w_rnd_sum[16]) begin
                            w_inum_n = 16'hFFFF;
                            w_ovf_n  = 1'b1;
                        end else begin
                            w_inum_n = w_rnd_sum[15:0];
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sig   <= 24'd0;
            r_cnt   <= 5'd0;
            r_inum  <= 16'h0000;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
`ifdef F2I_ROUND_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_sig   <= w_sig_n;
            r_cnt   <= w_cnt_n;
            r_inum  <= w_inum_n;
            r_ovf   <= w_ovf_n;
            r_neg   <= w_neg_n;
`ifdef F2I_ROUND_EN
            r_guard  <= w_guard_n;
            r_sticky <= w_sticky_n;
`endif
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign i_number  = r_inum;
    assign ovf       = r_ovf;
    assign neg       = r_neg;

endmodule

`default_nettype wire

// File: doc/f2i_seq.md
F2I_SEQ -- requirements
Module: f2i_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: f_number is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts f_number.
REQ-005 SHALL have port f_number, input, 32 bits: IEEE-754 single {sign, exponent[7:0], mantissa[22:0]}.
REQ-006 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-008 SHALL have port i_number, output, 16 bits: unsigned integer result.
REQ-009 SHALL have port ovf, output, 1 bit: the value exceeded 0xFFFF (saturated), or the input was Inf/NaN.
REQ-010 SHALL have port neg, output, 1 bit: the input was negative and nonzero (result clamped to 0).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 Accept SHALL occur on the edge where in_valid && in_ready; f_number is captured on that edge.
REQ-013 Special cases SHALL go from IDLE to DONE on accept, so out_valid rises the next cycle:
- exp==0 (zero or denormal): i_number 0, flags 0.
- exp==0xFF (Inf/NaN): i_number 0xFFFF, ovf 1.
- sign==1 and not zero: i_number 0, neg 1 (takes precedence over all except Inf/NaN).
- exp<127: i_number 0, flags 0 (except as REQ-019).
- exp>142: i_number 0xFFFF, ovf 1.
REQ-014 Normal case (127<=exp<=142, sign 0): on accept, load sig={1,mantissa} (24 bits) and cnt=150-exp (range 8..23), then go to SHIFT.
REQ-015 In SHIFT, each edge SHALL shift sig right by 1 and decrement cnt; on the edge where cnt==1, the FSM SHALL go to DONE.
REQ-016 Latency: accept edge at end of cycle T; out_valid SHALL be high from cycle T+1+cnt, i.e. T+9..T+24.
REQ-017 In DONE, i_number = sig[15:0] and flags SHALL be held stable while out_valid && !out_ready; on the edge with out_ready, the FSM SHALL return to IDLE and out_valid drops the next cycle.
REQ-018 in_valid SHALL be ignored outside IDLE; there is no back-to-back overlap, and the next accept is possible no earlier than the cycle after DONE exits.
REQ-019 Round-mode note: the exp<127 and neg paths SHALL be subject to REQ-024 only where stated.

Reset
REQ-020 While rst is high, the block SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, i_number 0, ovf 0, neg 0, cnt 0, sig 0.
REQ-021 A reset asserted mid-SHIFT or in DONE SHALL abort the conversion; no result is delivered, and after release the block is in IDLE ready to accept.

Configuration
REQ-022 The macro F2I_ROUND_EN SHALL select the rounding mode, with truncation toward zero when it is undefined.
REQ-023 Without F2I_ROUND_EN, the result SHALL be truncated toward zero; there are no guard/sticky registers.
REQ-024 With F2I_ROUND_EN:
- Each SHIFT edge SHALL update guard<=sig[0] and sticky<=sticky|guard.
- On entering DONE, the block SHALL round to nearest even: increment if guard && (sticky || sig[0]).
- If the incremented value wraps past 0xFFFF, the result SHALL be i_number 0xFFFF, ovf 1.
- exp==126 (value 0.5..1.0) SHALL take the SHIFT path with cnt=24 and round: exactly 0.5 gives 0, above 0.5 gives 1.
- Latency for the other cases SHALL be as in REQ-016.

Verification
REQ-025 Accept 0x3F800000 (1.0) at cycle T -> out_valid at T+24, i_number 0x0001, ovf 0, neg 0.
REQ-026 Accept 0x477FFF00 (65535.0) -> out_valid at T+9, i_number 0xFFFF, ovf 0; accept 0x47800000 (65536.0) -> out_valid at T+1, i_number 0xFFFF, ovf 1.
REQ-027 Specials: 0x00000000 -> 0x0000 at T+1; 0xC0000000 (-2.0) -> 0x0000, neg 1; 0x7FC00000 (NaN) -> 0xFFFF, ovf 1; 0x80000000 (-0.0) -> 0x0000, neg 0.
REQ-028 Backpressure: hold out_ready 0 for 5 cycles in DONE -> i_number/flags stable, in_ready 0, in_valid pulses ignored; raise out_ready -> IDLE next cycle.
REQ-029 0x40200000 (2.5) and 0x40600000 (3.5) -> 2 and 3 without the macro; 2 and 4 with F2I_ROUND_EN; with the macro, 0x477FFF80 (65535.5) -> 0xFFFF, ovf 1.
REQ-030 Assert rst at T+5 during a 1.0 conversion -> outputs immediately at reset values, no out_valid; after release, accept 0x41200000 (10.0) -> 0x000A.
